// File: rtl/shader_pkg.sv
// rtl/shader_pkg.sv - shared warp scheduler constants and warp state type
package shader_pkg;

   localparam int NUM_WARPS   = 16;
   localparam int WID_W       = $clog2(NUM_WARPS);
   localparam int ALU_LATENCY = 3;

   typedef enum logic [1:0] {
      WS_IDLE     = 2'd0,
      WS_READY    = 2'd1,
      WS_WAIT_ALU = 2'd2,
      WS_WAIT_MEM = 2'd3
   } warp_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter: first request at or after ptr, wrapping
module rr_arbiter #(
   parameter int N  = 16,
   parameter int IW = 4
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_id,
   output logic          grant_valid
);

   int idx;

   always_comb begin
      grant       = '0;
      grant_id    = '0;
      grant_valid = 1'b0;
      idx         = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (!grant_valid && req[idx[IW-1:0]]) begin
            grant_valid             = 1'b1;
            grant[idx[IW-1:0]]      = 1'b1;
            grant_id                = idx[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/warp_scheduler.sv
// rtl/warp_scheduler.sv - per-warp state tracking with round-robin locked issue offer
module warp_scheduler #(
   parameter int NUM_WARPS   = shader_pkg::NUM_WARPS,
   parameter int ALU_LATENCY = shader_pkg::ALU_LATENCY,
   parameter int WID_W       = shader_pkg::WID_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 launch_valid,
   input  logic [WID_W-1:0]     launch_warp,
   input  logic [NUM_WARPS-1:0] instr_avail,
   input  logic [NUM_WARPS-1:0] instr_is_mem,
   input  logic [NUM_WARPS-1:0] instr_is_last,
   output logic                 issue_valid,
   output logic [WID_W-1:0]     issue_warp,
   input  logic                 issue_ready,
   input  logic                 mem_done_valid,
   input  logic [WID_W-1:0]     mem_done_warp,
   output logic [WID_W:0]       active_count,
   output logic                 busy,
   output logic [31:0]          issue_count
);

   import shader_pkg::*;

   localparam int LAT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

   warp_state_e            state     [NUM_WARPS];
   warp_state_e            state_nxt [NUM_WARPS];
   logic [LAT_W-1:0]       lat       [NUM_WARPS];
   logic [LAT_W-1:0]       lat_nxt   [NUM_WARPS];

   logic [WID_W-1:0]       rr_ptr;
   logic [WID_W-1:0]       rr_ptr_nxt;
   logic                   lock;
   logic [WID_W-1:0]       lock_id;
   logic [NUM_WARPS-1:0]   lock_vec;
   logic [31:0]            hs_count;

   logic [NUM_WARPS-1:0]   eligible;
   logic [NUM_WARPS-1:0]   grant_vec;
   logic [NUM_WARPS-1:0]   offer_vec;
   logic [WID_W-1:0]       grant_id;
   logic                   grant_valid;
   logic                   handshake;

   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         eligible[i] = (state[i] == WS_READY) && instr_avail[i];
      end
   end

   rr_arbiter #(
      .N  (NUM_WARPS),
      .IW (WID_W)
   ) u_arb (
      .req         (eligible),
      .ptr         (rr_ptr),
      .grant       (grant_vec),
      .grant_id    (grant_id),
      .grant_valid (grant_valid)
   );

   // A stalled offer stays pinned to its warp until the core takes it.
   always_comb begin
      issue_valid = lock | grant_valid;
      issue_warp  = lock ? lock_id : grant_id;
      offer_vec   = lock ? lock_vec : grant_vec;
      handshake   = issue_valid && issue_ready;
   end

   always_comb begin
      for (int i = 0; i < NUM_WARPS; i++) begin
         state_nxt[i] = state[i];
         lat_nxt[i]   = lat[i];
         case (state[i])
            WS_IDLE: begin
               if (launch_valid && (launch_warp == WID_W'(i))) begin
                  state_nxt[i] = WS_READY;
               end
            end
            WS_READY: begin
               if (handshake && offer_vec[i]) begin
                  if (instr_is_last[i]) begin
                     state_nxt[i] = WS_IDLE;
                  end else if (instr_is_mem[i]) begin
                     state_nxt[i] = WS_WAIT_MEM;
                  end else if (ALU_LATENCY > 1) begin
                     state_nxt[i] = WS_WAIT_ALU;
                     lat_nxt[i]   = LAT_W'(ALU_LATENCY - 1);
                  end
               end
            end
            // READY is entered on the edge where the counter reads 1.
            WS_WAIT_ALU: begin
               if (lat[i] <= LAT_W'(1)) begin
                  state_nxt[i] = WS_READY;
                  lat_nxt[i]   = '0;
               end else begin
                  lat_nxt[i] = lat[i] - LAT_W'(1);
               end
            end
            WS_WAIT_MEM: begin
               if (mem_done_valid && (mem_done_warp == WID_W'(i))) begin
                  state_nxt[i] = WS_READY;
               end
            end
            default: state_nxt[i] = WS_IDLE;
         endcase
      end
   end

   always_comb begin
      rr_ptr_nxt = rr_ptr;
      if (handshake) begin
         rr_ptr_nxt = (issue_warp == WID_W'(NUM_WARPS - 1)) ? '0 : issue_warp + WID_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_WARPS; i++) begin
            state[i] <= WS_IDLE;
            lat[i]   <= '0;
         end
         rr_ptr   <= '0;
         lock     <= 1'b0;
         lock_id  <= '0;
         lock_vec <= '0;
         hs_count <= '0;
      end else begin
         for (int i = 0; i < NUM_WARPS; i++) begin
            state[i] <= state_nxt[i];
            lat[i]   <= lat_nxt[i];
         end
         rr_ptr <= rr_ptr_nxt;
         if (issue_valid && !issue_ready) begin
            lock     <= 1'b1;
            lock_id  <= issue_warp;
            lock_vec <= offer_vec;
         end else if (handshake) begin
            lock <= 1'b0;
         end
         if (handshake) begin
            hs_count <= hs_count + 32'd1;
         end
      end
   end

   always_comb begin
      active_count = '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         if (state[i] != WS_IDLE) begin
            active_count = active_count + (WID_W + 1)'(1);
         end
      end
      busy        = (active_count != '0);
      issue_count = hs_count;
   end

endmodule

// File: tb/tb_warp_scheduler.sv
// tb/tb_warp_scheduler.sv - directed self-checking bench for warp_scheduler
module tb_warp_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        launch_valid;
   logic [3:0]  launch_warp;
   logic [15:0] instr_avail;
   logic [15:0] instr_is_mem;
   logic [15:0] instr_is_last;
   logic        issue_valid;
   logic [3:0]  issue_warp;
   logic        issue_ready;
   logic        mem_done_valid;
   logic [3:0]  mem_done_warp;
   logic [4:0]  active_count;
   logic        busy;
   logic [31:0] issue_count;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_order [4] = '{0, 1, 15, 0};

   warp_scheduler dut (
      .clk            (clk),
      .rst            (rst),
      .launch_valid   (launch_valid),
      .launch_warp    (launch_warp),
      .instr_avail    (instr_avail),
      .instr_is_mem   (instr_is_mem),
      .instr_is_last  (instr_is_last),
      .issue_valid    (issue_valid),
      .issue_warp     (issue_warp),
      .issue_ready    (issue_ready),
      .mem_done_valid (mem_done_valid),
      .mem_done_warp  (mem_done_warp),
      .active_count   (active_count),
      .busy           (busy),
      .issue_count    (issue_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      launch_valid   = 1'b0;
      launch_warp    = 4'd0;
      instr_avail    = 16'h0000;
      instr_is_mem   = 16'h0000;
      instr_is_last  = 16'h0000;
      issue_ready    = 1'b0;
      mem_done_valid = 1'b0;
      mem_done_warp  = 4'd0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      step();
      step();
      #1;
      chk("rst_issue_valid", 32'(issue_valid), 32'd0);
      chk("rst_issue_warp", 32'(issue_warp), 32'd0);
      chk("rst_active_count", 32'(active_count), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_issue_count", issue_count, 32'd0);
      rst = 1'b0;

      // lone ALU warp: handshakes every third cycle
      launch_valid = 1'b1;
      launch_warp  = 4'd5;
      instr_avail  = 16'h0020;
      issue_ready  = 1'b1;
      step();
      launch_valid = 1'b0;
      #1;
      chk("alu_active_count", 32'(active_count), 32'd1);
      chk("alu_busy", 32'(busy), 32'd1);
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("alu_valid_k%0d", k), 32'(issue_valid), (k % 3 == 0) ? 32'd1 : 32'd0);
         if (k % 3 == 0) begin
            chk($sformatf("alu_warp_k%0d", k), 32'(issue_warp), 32'd5);
         end
         step();
      end
      #1;
      chk("alu_issue_count", issue_count, 32'd3);

      // round-robin order with pointer wrap 15 -> 0
      do_reset();
      launch_valid = 1'b1;
      launch_warp  = 4'd0;
      step();
      launch_warp  = 4'd1;
      step();
      launch_warp  = 4'd15;
      step();
      launch_valid = 1'b0;
      instr_avail  = 16'h8003;
      issue_ready  = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rr_valid_%0d", k), 32'(issue_valid), 32'd1);
         chk($sformatf("rr_warp_%0d", k), 32'(issue_warp), 32'(exp_order[k]));
         step();
      end
      #1;
      chk("rr_issue_count", issue_count, 32'd4);
      chk("rr_active_count", 32'(active_count), 32'd3);

      // stalled offer stays locked on warp 2
      do_reset();
      launch_valid = 1'b1;
      launch_warp  = 4'd2;
      instr_avail  = 16'h0004;
      step();
      launch_warp  = 4'd1;
      instr_avail  = 16'h0006;
      #1;
      chk("lock_warp_c0", 32'(issue_warp), 32'd2);
      step();
      launch_valid = 1'b0;
      instr_avail  = 16'h0002;
      #1;
      chk("lock_valid_c1", 32'(issue_valid), 32'd1);
      chk("lock_warp_c1", 32'(issue_warp), 32'd2);
      step();
      instr_avail = 16'h0006;
      #1;
      chk("lock_warp_c2", 32'(issue_warp), 32'd2);
      step();
      #1;
      chk("lock_warp_c3", 32'(issue_warp), 32'd2);
      issue_ready = 1'b1;
      step();
      #1;
      chk("lock_next_valid", 32'(issue_valid), 32'd1);
      chk("lock_next_warp", 32'(issue_warp), 32'd1);
      chk("lock_issue_count", issue_count, 32'd1);

      // memory wait, stray mem_done on an idle warp, then wake-up
      do_reset();
      issue_ready  = 1'b1;
      launch_valid = 1'b1;
      launch_warp  = 4'd3;
      instr_avail  = 16'h0008;
      instr_is_mem = 16'h0008;
      step();
      launch_valid = 1'b0;
      #1;
      chk("mem_first_valid", 32'(issue_valid), 32'd1);
      chk("mem_first_warp", 32'(issue_warp), 32'd3);
      step();
      for (int k = 1; k <= 10; k++) begin
         mem_done_valid = (k == 5) || (k == 10);
         mem_done_warp  = (k == 5) ? 4'd7 : 4'd3;
         #1;
         chk($sformatf("mem_wait_valid_%0d", k), 32'(issue_valid), 32'd0);
         if (k == 6) begin
            chk("mem_stray_active", 32'(active_count), 32'd1);
         end
         step();
      end
      mem_done_valid = 1'b0;
      #1;
      chk("mem_wake_valid", 32'(issue_valid), 32'd1);
      chk("mem_wake_warp", 32'(issue_warp), 32'd3);

      // retire warp 4 while a launch of warp 4 arrives in the same cycle
      do_reset();
      issue_ready  = 1'b1;
      launch_valid = 1'b1;
      launch_warp  = 4'd6;
      step();
      launch_warp   = 4'd4;
      step();
      instr_avail   = 16'h0010;
      instr_is_last = 16'h0010;
      instr_is_mem  = 16'h0010;
      #1;
      chk("last_active_before", 32'(active_count), 32'd2);
      chk("last_offer_warp", 32'(issue_warp), 32'd4);
      step();
      launch_valid = 1'b0;
      #1;
      chk("last_active_after", 32'(active_count), 32'd1);
      chk("last_valid_after", 32'(issue_valid), 32'd0);
      step();
      #1;
      chk("last_active_hold", 32'(active_count), 32'd1);
      chk("last_issue_count", issue_count, 32'd1);

      // reset during a locked offer with three warps active
      instr_avail   = 16'h0000;
      instr_is_last = 16'h0000;
      instr_is_mem  = 16'h0000;
      launch_valid  = 1'b1;
      launch_warp   = 4'd8;
      step();
      launch_warp   = 4'd9;
      step();
      launch_valid  = 1'b0;
      instr_avail   = 16'h0100;
      issue_ready   = 1'b0;
      #1;
      chk("rstl_active", 32'(active_count), 32'd3);
      chk("rstl_offer", 32'(issue_warp), 32'd8);
      step();
      #1;
      chk("rstl_locked_valid", 32'(issue_valid), 32'd1);
      rst          = 1'b1;
      issue_ready  = 1'b1;
      launch_valid = 1'b1;
      launch_warp  = 4'd10;
      step();
      rst          = 1'b0;
      launch_valid = 1'b0;
      #1;
      chk("rstl_valid", 32'(issue_valid), 32'd0);
      chk("rstl_active_count", 32'(active_count), 32'd0);
      chk("rstl_busy", 32'(busy), 32'd0);
      chk("rstl_issue_count", issue_count, 32'd0);
      step();
      #1;
      chk("rstl_post_valid", 32'(issue_valid), 32'd0);
      chk("rstl_post_active", 32'(active_count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/warp_scheduler.md
WARP_SCHEDULER -- requirements
Module: warp_scheduler

Interface
REQ-001 Parameter NUM_WARPS, default 16: number of warp slots.
REQ-002 Parameter ALU_LATENCY, default 3: minimum cycles between two issues of one warp for ALU instructions.
REQ-003 Parameter WID_W, default 4: warp-id width, $clog2(NUM_WARPS).
REQ-004 One clock and one reset: the reset is synchronous and active-high.
REQ-005 clk, input, 1: clock; all state updates on the rising edge.
REQ-006 rst, input, 1: synchronous active-high reset.
REQ-007 launch_valid, input, 1: activate the warp named by launch_warp.
REQ-008 launch_warp, input, WID_W: warp to activate.
REQ-009 instr_avail, input, NUM_WARPS: per-warp flag, fetched instruction present.
REQ-010 instr_is_mem, input, NUM_WARPS: per-warp flag, pending instruction is a memory op.
REQ-011 instr_is_last, input, NUM_WARPS: per-warp flag, pending instruction ends the warp.
REQ-012 issue_valid, output, 1: a warp is offered for issue to the shader core.
REQ-013 issue_warp, output, WID_W: offered warp id.
REQ-014 issue_ready, input, 1: shader core accepts; handshake = issue_valid && issue_ready.
REQ-015 mem_done_valid, input, 1: memory op completed for mem_done_warp.
REQ-016 mem_done_warp, input, WID_W: warp whose memory op completed.
REQ-017 active_count, output, WID_W+1: number of non-IDLE warps.
REQ-018 busy, output, 1: high when active_count != 0.
REQ-019 issue_count, output, 32: handshake counter, wraps at 2^32.

Function
REQ-020 Per-warp state: IDLE, READY, WAIT_ALU, WAIT_MEM, plus a latency down-counter.
REQ-021 IDLE->READY on launch_valid for that warp; launch of a non-IDLE warp is ignored.
REQ-022 A warp is eligible when it is READY and its instr_avail bit is 1.
REQ-023 Round-robin arbitration: select the first eligible warp at or after rr_ptr, modulo NUM_WARPS.
REQ-024 On handshake with warp W: rr_ptr <= (W+1) mod NUM_WARPS; issue_count increments.
REQ-025 The offer is combinational from registered state, so issue_valid may rise in the cycle a warp becomes eligible.
REQ-026 While issue_valid=1 and issue_ready=0, issue_warp and issue_valid are held (locked) until the handshake, regardless of instr_avail or new eligibility.
REQ-027 Handshake with is_last=1: W goes to IDLE and is_mem is ignored.
REQ-028 Handshake with is_mem=1 and is_last=0: W goes to WAIT_MEM.
REQ-029 Handshake with neither flag set: W goes to WAIT_ALU.
REQ-030 WAIT_ALU: W returns to READY so that its next handshake occurs no earlier than ALU_LATENCY cycles after the previous one; with ALU_LATENCY=3 a lone warp issues on cycles 0, 3, 6.
REQ-031 WAIT_MEM: W goes to READY on the edge sampling mem_done_valid with mem_done_warp=W.
REQ-032 mem_done for a warp not in WAIT_MEM is ignored; no state change, no error.
REQ-033 Simultaneous launch, mem_done and handshake events on distinct warps are all applied in the same cycle.
REQ-034 Launch of the warp retiring in the same cycle is ignored.
REQ-035 active_count and busy reflect registered state, so they update one cycle after the causing event.

Reset
REQ-036 On rst: all warps IDLE, latency counters 0, rr_ptr 0, lock cleared, issue_count 0.
REQ-037 Reset values of outputs: issue_valid 0, issue_warp 0, active_count 0, busy 0, issue_count 0.
REQ-038 Reset asserted mid-operation discards any locked offer and all pending WAIT states.
REQ-039 Reset has priority over all other inputs in the same cycle.

Structure
REQ-040 Shared package shader_pkg holds NUM_WARPS, WID_W, ALU_LATENCY and the enum warp_state_e.
REQ-041 Sub-module rr_arbiter (NUM_WARPS request vector and pointer in, one-hot grant and encoded id out) is instantiated once.

Verification
REQ-042 Launch warp 5, instr_avail[5]=1, ready=1, no flags -> handshakes on warp 5 at cycles spaced exactly 3 apart; issue_count=3 after 3 issues.
REQ-043 Warps 0, 1 and 15 READY and available, ready=1 -> grant order 0, 1, 15, 0; rr_ptr wraps from 15 to 0.
REQ-044 Offer warp 2 with ready=0 for 4 cycles while warp 1 becomes eligible -> issue_warp stays 2 until the handshake; warp 1 is granted next.
REQ-045 Warp 3 issues with is_mem=1; mem_done for warp 3 arrives 10 cycles later -> no issue for warp 3 in between; warp 3 is eligible the cycle after mem_done.
REQ-046 Warp 4 issues with is_last=1 while a launch of warp 4 occurs in the same cycle -> warp 4 ends IDLE; active_count decrements by 1 one cycle later.
REQ-047 rst asserted during a locked offer with 3 warps active -> next cycle issue_valid=0, active_count=0, busy=0, issue_count=0.
